// File: rtl/hbm_stream_unpacker.sv
// rtl/hbm_stream_unpacker.sv - HBM read-beat FIFO and beat-to-element unpacker
module hbm_stream_unpacker #(
    parameter int IN_WIDTH     = 256,
    parameter int OUT_WIDTH    = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    input  logic [IN_WIDTH-1:0]                in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_WIDTH-1:0]               out_data,
    output logic                               out_last,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               almost_full,
    output logic                               overflow,
    output logic [15:0]                        drop_count
);
    localparam int LANES = IN_WIDTH / OUT_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_TH = CNT_W'(FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [IN_WIDTH-1:0]            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]               count_q;
    logic [LANES-1:0][OUT_WIDTH-1:0] hold_q;
    logic                           ovf_q;
    logic [15:0]                    drops_q;
    logic                           fifo_full, fifo_empty;
    logic                           wr_en, drop_en, pop;

    // Full/empty come from the occupancy count, so a pop never frees a slot for the same edge.
    assign fifo_full   = (count_q == DEPTH_C);
    assign fifo_empty  = (count_q == '0);
    assign wr_en       = in_valid & ~flush & ~fifo_full;
    assign drop_en     = in_valid & ~flush & fifo_full;

    assign fifo_count  = count_q;
    assign almost_full = (count_q >= AFULL_TH);
    assign overflow    = ovf_q;
    assign drop_count  = drops_q;

    // Holding-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state, pop decision and element outputs; last-lane handshake reloads without a bubble.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pop       = 1'b0;
        out_valid = (state_q == ST_HOLD);
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == ST_HOLD) begin
            out_data = hold_q[idx_q];
            out_last = (idx_q == LAST_IDX);
        end
        if (flush) begin
            state_d = ST_EMPTY;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_HOLD;
                        idx_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        if (idx_q != LAST_IDX) begin
                            idx_d = idx_q + 1'b1;
                        end else if (!fifo_empty) begin
                            pop   = 1'b1;
                            idx_d = '0;
                        end else begin
                            state_d = ST_EMPTY;
                            idx_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; flush empties the queue regardless of traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Beat storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= in_data;
    end

    // Holding register captures the FIFO head on every pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (pop) begin
            hold_q <= mem[rd_ptr_q];
        end
    end

    // Sticky overflow and saturating drop counter, cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else if (flush) begin
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else if (drop_en) begin
            ovf_q <= 1'b1;
            if (drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_hbm_stream_unpacker.sv
// tb/tb_hbm_stream_unpacker.sv - scoreboard bench for hbm_stream_unpacker
module tb_hbm_stream_unpacker;
    localparam int IN_WIDTH     = 256;
    localparam int OUT_WIDTH    = 32;
    localparam int FIFO_DEPTH   = 16;
    localparam int AFULL_MARGIN = 4;
    localparam int LANES        = IN_WIDTH / OUT_WIDTH;
    localparam int CW           = $clog2(FIFO_DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic [IN_WIDTH-1:0]   in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_last;
    logic [CW-1:0]         fifo_count;
    logic                  almost_full;
    logic                  overflow;
    logic [15:0]           drop_count;

    always #5 clk = ~clk;

    hbm_stream_unpacker #(
        .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH), .AFULL_MARGIN(AFULL_MARGIN)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .fifo_count(fifo_count), .almost_full(almost_full),
        .overflow(overflow), .drop_count(drop_count)
    );

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 last;
    } elem_t;

    elem_t exp_q[$];
    int    m_cnt   = 0;   // beats waiting in the FIFO
    int    m_rem   = 0;   // elements left in the holding register (0 = nothing held)
    int    m_drops = 0;
    bit    m_ovf   = 0;
    int    errors  = 0;
    int    checks  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [IN_WIDTH-1:0] rand_beat();
        logic [IN_WIDTH-1:0] b;
        for (int i = 0; i < LANES; i++) b[i*OUT_WIDTH +: OUT_WIDTH] = $urandom();
        return b;
    endfunction

    // Behavioural reference: beats are counted, accepted beats expand into the expected element queue.
    task automatic model_edge(input bit iv, input logic [IN_WIDTH-1:0] d, input bit fl, input bit rdy);
        bit hs, pop, wr;
        if (fl) begin
            m_cnt = 0; m_rem = 0; m_ovf = 0; m_drops = 0;
            exp_q.delete();
            return;
        end
        hs  = (m_rem > 0) && rdy;
        pop = (m_cnt > 0) && ((m_rem == 0) || (hs && m_rem == 1));
        wr  = 0;
        if (iv) begin
            if (m_cnt < FIFO_DEPTH) begin
                wr = 1;
                for (int i = 0; i < LANES; i++)
                    exp_q.push_back('{data: d[i*OUT_WIDTH +: OUT_WIDTH], last: (i == LANES-1)});
            end else begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
        m_cnt = m_cnt + int'(wr) - int'(pop);
        if (pop)     m_rem = LANES;
        else if (hs) m_rem = m_rem - 1;
    endtask

    task automatic cycle(input bit iv, input logic [IN_WIDTH-1:0] d, input bit fl, input bit rdy);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = rdy;
        @(posedge clk);
        model_edge(iv, d, fl, rdy);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},   out_valid,   0);
        check({tag, "_out_data"},    out_data,    0);
        check({tag, "_out_last"},    out_last,    0);
        check({tag, "_fifo_count"},  fifo_count,  0);
        check({tag, "_almost_full"}, almost_full, 0);
        check({tag, "_overflow"},    overflow,    0);
        check({tag, "_drop_count"},  drop_count,  0);
    endtask

    // Asynchronous reset asserted mid-cycle, released just after the following edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst");
        m_cnt = 0; m_rem = 0; m_ovf = 0; m_drops = 0;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: compares every DUT output against the model between edges; pops on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("out_valid",   out_valid,   m_rem > 0);
            check("fifo_count",  fifo_count,  m_cnt);
            check("almost_full", almost_full, m_cnt >= FIFO_DEPTH - AFULL_MARGIN);
            check("overflow",    overflow,    m_ovf);
            check("drop_count",  drop_count,  m_drops);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("valid_without_expected", out_valid, 0);
                end else begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_last", out_last, exp_q[0].last);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [IN_WIDTH-1:0] ramp;
        for (int i = 0; i < LANES; i++) ramp[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(i);

        @(posedge clk);
        #1;
        check_reset_outputs("init");
        rst = 1'b0;

        // Single ramp beat, ready held high.
        cycle(1, ramp, 0, 1);
        check("latency_edge1_valid", out_valid, 0);
        cycle(0, '0, 0, 1);
        check("latency_edge2_valid", out_valid, 1);
        check("latency_lane0", out_data, 0);
        for (int k = 0; k < 10; k++) cycle(0, '0, 0, 1);

        // Four back-to-back beats.
        for (int k = 0; k < 4; k++) cycle(1, rand_beat(), 0, 1);
        for (int k = 0; k < 40; k++) cycle(0, '0, 0, 1);

        // Stalled consumer, 20 beats in 20 cycles.
        for (int k = 0; k < 20; k++) cycle(1, rand_beat(), 0, 0);
        check("stall_count", fifo_count, 16);
        check("stall_drops", drop_count, 3);
        check("stall_ovf",   overflow,   1);
        check("stall_afull", almost_full, 1);

        // Walk to the last lane, then a write lands on the pop edge while full.
        for (int k = 0; k < LANES-1; k++) cycle(0, '0, 0, 1);
        check("last_lane_flag", out_last, 1);
        cycle(1, rand_beat(), 0, 1);
        check("pop_write_count", fifo_count, 15);
        check("pop_write_drops", drop_count, 4);

        // Drain to five buffered beats, then flush with a coincident beat.
        for (int k = 0; k < 400 && m_cnt > 5; k++) cycle(0, '0, 0, 1);
        check("preflush_count", fifo_count, 5);
        cycle(1, rand_beat(), 1, 0);
        check("flush_count", fifo_count, 0);
        check("flush_valid", out_valid, 0);
        check("flush_ovf",   overflow, 0);
        check("flush_drops", drop_count, 0);
        for (int k = 0; k < 4; k++) cycle(0, '0, 0, 1);

        // Reset while the holding register sits on lane 3.
        cycle(1, ramp, 0, 0);
        cycle(0, '0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, '0, 0, 1);
        check("mid_lane3", out_data, 3);
        out_ready = 1'b0;
        do_reset();
        cycle(1, rand_beat(), 0, 1);
        for (int k = 0; k < 12; k++) cycle(0, '0, 0, 1);

        // Randomised traffic with occasional flushes.
        for (int k = 0; k < 800; k++)
            cycle($urandom_range(0, 99) < 55, rand_beat(), $urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 70);

        // Drain whatever remains.
        for (int k = 0; k < 300 && (exp_q.size() != 0 || m_cnt != 0); k++) cycle(0, '0, 0, 1);
        check("drain_remaining", exp_q.size(), 0);
        check("drain_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
